// File: rtl/llc_mem_responder_pkg.sv
// Shared cache constants and types for the LLC memory-side responder.
package llc_mem_responder_pkg;

  localparam int unsigned LINE_ADDR_BITS = 26;
  localparam int unsigned BITS_PER_LINE  = 128;
  localparam int unsigned LAT_CNT_BITS   = 8;

  typedef logic [BITS_PER_LINE-1:0]  line_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } llc_mem_rsp_state_t;

endpackage

// File: rtl/llc_mem_responder_store.sv
// Line store: one write port, one synchronous read port with a resettable
// output register. Kept separate so BRAM/SRAM macros can replace it.
module llc_mem_responder_store
  import llc_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LINES = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_t            wr_line,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output line_t            rd_line
);

  line_t mem [MEM_LINES];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_line;
    end
  end

  // Registered read; the register only updates when a read is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line <= '0;
    end else if (rd_en) begin
      rd_line <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/llc_mem_responder.sv
// Memory-side endpoint of the LLC mem_req/mem_rsp channel.
// Writes complete in one cycle; reads return after RD_LATENCY cycles.
// Optional feature macro: LLC_MEM_RSP_STATS_EN adds rd_count/wr_count.
module llc_mem_responder
  import llc_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LINES  = 1024,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      llc_mem_req_valid,
  output logic                      llc_mem_req_ready,
  input  logic                      llc_mem_req_hwrite,
  input  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr,
  input  logic [BITS_PER_LINE-1:0]  llc_mem_req_line,
  output logic                      llc_mem_rsp_valid,
  input  logic                      llc_mem_rsp_ready,
  output logic [BITS_PER_LINE-1:0]  llc_mem_rsp_line
`ifdef LLC_MEM_RSP_STATS_EN
  ,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
`endif
);

  localparam int unsigned IDX_W = $clog2(MEM_LINES);
  localparam logic [LAT_CNT_BITS-1:0] LAT_LOAD =
    (RD_LATENCY >= 2) ? LAT_CNT_BITS'(RD_LATENCY - 2) : '0;

  llc_mem_rsp_state_t      state_q, state_d;
  logic [LAT_CNT_BITS-1:0] lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    wr_en, rd_en;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        req_idx;
  logic                    req_fire;
  logic                    unused_addr_hi;

  // Upper line-address bits alias onto the same index.
  assign req_idx        = llc_mem_req_addr[IDX_W-1:0];
  assign unused_addr_hi = ^llc_mem_req_addr[LINE_ADDR_BITS-1:IDX_W];

  // Ready follows state directly so the upstream sees it in the same cycle.
  assign llc_mem_req_ready = (state_q == IDLE) && !rst;
  assign req_fire          = llc_mem_req_valid && llc_mem_req_ready;
  assign llc_mem_rsp_valid = rsp_valid_q;

  // State, latency counter, latched index and response-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state, store strobes and response-valid update.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = idx_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (llc_mem_req_hwrite) begin
            wr_en = 1'b1;
          end else begin
            idx_d = req_idx;
            if (RD_LATENCY == 1) begin
              rd_en       = 1'b1;
              rd_idx      = req_idx;
              rsp_valid_d = 1'b1;
              state_d     = RSP;
            end else begin
              lat_cnt_d = LAT_LOAD;
              state_d   = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          rd_en       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_BITS'(1);
        end
      end
      RSP: begin
        if (llc_mem_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  llc_mem_responder_store #(
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (req_idx),
    .wr_line (llc_mem_req_line),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_line (llc_mem_rsp_line)
  );

`ifdef LLC_MEM_RSP_STATS_EN
  // Accepted-request counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (req_fire) begin
      if (llc_mem_req_hwrite) begin
        wr_count <= wr_count + 32'd1;
      end else begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_llc_mem_responder.sv
// Self-checking bench for llc_mem_responder (RD_LATENCY=4 and RD_LATENCY=1 instances).
module tb_llc_mem_responder;
  import llc_mem_responder_pkg::*;

  localparam int unsigned MEM_LINES = 1024;
  localparam int          RD_LAT    = 4;
  localparam int          TIMEOUT   = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       req_valid = 1'b0, req_ready, req_hwrite = 1'b0;
  line_addr_t req_addr = '0;
  line_t      req_line = '0;
  logic       rsp_valid, rsp_ready = 1'b1;
  line_t      rsp_line;

  logic       l1_req_valid = 1'b0, l1_req_ready, l1_req_hwrite = 1'b0;
  line_addr_t l1_req_addr = '0;
  line_t      l1_req_line = '0;
  logic       l1_rsp_valid, l1_rsp_ready = 1'b1;
  line_t      l1_rsp_line;

`ifdef LLC_MEM_RSP_STATS_EN
  logic [31:0] rd_count, wr_count, l1_rd_count, l1_wr_count;
`endif

  // Reference model: plain line array indexed by address modulo MEM_LINES.
  line_t model   [MEM_LINES];
  bit    written [MEM_LINES];
  int    wq[$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  llc_mem_responder #(.MEM_LINES(MEM_LINES), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(req_valid), .llc_mem_req_ready(req_ready),
    .llc_mem_req_hwrite(req_hwrite), .llc_mem_req_addr(req_addr),
    .llc_mem_req_line(req_line),
    .llc_mem_rsp_valid(rsp_valid), .llc_mem_rsp_ready(rsp_ready),
    .llc_mem_rsp_line(rsp_line)
`ifdef LLC_MEM_RSP_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  llc_mem_responder #(.MEM_LINES(MEM_LINES), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(l1_req_valid), .llc_mem_req_ready(l1_req_ready),
    .llc_mem_req_hwrite(l1_req_hwrite), .llc_mem_req_addr(l1_req_addr),
    .llc_mem_req_line(l1_req_line),
    .llc_mem_rsp_valid(l1_rsp_valid), .llc_mem_rsp_ready(l1_rsp_ready),
    .llc_mem_rsp_line(l1_rsp_line)
`ifdef LLC_MEM_RSP_STATS_EN
    , .rd_count(l1_rd_count), .wr_count(l1_wr_count)
`endif
  );

  function automatic line_t rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int idx_of(input line_addr_t a);
    return int'(a % MEM_LINES);
  endfunction

  // Drivers (called at a negedge, return at a negedge).
  task automatic wait_req_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
  endtask

  task automatic do_write(input line_addr_t a, input line_t d);
    wait_req_ready();
    req_valid = 1'b1; req_hwrite = 1'b1; req_addr = a; req_line = d;
    @(negedge clk);
    req_valid = 1'b0; req_hwrite = 1'bx; req_addr = 'x; req_line = 'x;
    model[idx_of(a)] = d;
    if (!written[idx_of(a)]) begin
      written[idx_of(a)] = 1'b1;
      wq.push_back(idx_of(a));
    end
  endtask

  // Returns lat = number of cycles after the accept edge until valid is seen.
  task automatic do_read(input line_addr_t a, output int lat, output line_t data);
    wait_req_ready();
    req_valid = 1'b1; req_hwrite = 1'b0; req_addr = a; req_line = 'x;
    @(negedge clk);
    req_valid = 1'b0; req_hwrite = 1'bx; req_addr = 'x;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    data = rsp_line;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_line !== '0) begin
        miscompares++;
        $display("FAIL reset_state: ready=%b valid=%b line=%h, required 0/0/0", req_ready, rsp_valid, rsp_line);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_basic_read();
    int lat; line_t got; line_t pat;
    pat = {16{8'hA5}};
    rsp_ready = 1'b1;
    do_write(line_addr_t'(26'h40), pat);
    do_read(line_addr_t'(26'h40), lat, got);
    vectors++;
    if (lat != RD_LAT) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", lat, RD_LAT);
    end
    vectors++;
    if (got !== pat) begin
      miscompares++;
      $display("FAIL basic_data: got %h, required %h", got, pat);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after_hs: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat; line_t got; line_t d;
    d = rnd_line();
    do_write(line_addr_t'(26'h123), d);
    rsp_ready = 1'b0;
    do_read(line_addr_t'(26'h123), lat, got);
    vectors++;
    if (lat != RD_LAT || got !== d) begin
      miscompares++;
      $display("FAIL bp_first: lat=%0d data=%h, required %0d/%h", lat, got, RD_LAT, d);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_line !== d || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b line=%h, required 1/0/%h", i, rsp_valid, req_ready, rsp_line, d);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat; line_t got; line_t d;
    wait_req_ready();
    for (int i = 0; i < 8; i++) begin
      d = rnd_line();
      req_valid = 1'b1; req_hwrite = 1'b1; req_addr = line_addr_t'(i); req_line = d;
      model[i] = d;
      if (!written[i]) begin written[i] = 1'b1; wq.push_back(i); end
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: ready=%b, required 1", i, req_ready);
      end
    end
    req_valid = 1'b0; req_hwrite = 1'bx; req_addr = 'x; req_line = 'x;
    for (int i = 0; i < 8; i++) begin
      do_read(line_addr_t'(i), lat, got);
      vectors++;
      if (lat != RD_LAT || got !== model[i]) begin
        miscompares++;
        $display("FAIL b2b_read[%0d]: lat=%0d data=%h, required %0d/%h", i, lat, got, RD_LAT, model[i]);
      end
      @(negedge clk);
    end
    d = rnd_line();
    do_write(line_addr_t'(26'h400), d);
    do_read(line_addr_t'(26'h0), lat, got);
    vectors++;
    if (got !== d) begin
      miscompares++;
      $display("FAIL alias_0x400: got %h, required %h", got, d);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bp, idx; line_t got; line_t d; line_addr_t a;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0 || wq.size() == 0) begin
        a = line_addr_t'($urandom);
        d = rnd_line();
        do_write(a, d);
      end else begin
        idx = wq[$urandom_range(0, wq.size() - 1)];
        a = line_addr_t'($urandom_range(0, 65535) * MEM_LINES + idx);
        bp = $urandom_range(0, 3);
        rsp_ready = (bp == 0);
        do_read(a, lat, got);
        vectors++;
        if (lat != RD_LAT || got !== model[idx]) begin
          miscompares++;
          $display("FAIL rand_read[%0d] addr=%h: lat=%0d data=%h, required %0d/%h", i, a, lat, got, RD_LAT, model[idx]);
        end
        for (int j = 0; j < bp; j++) begin
          @(negedge clk);
          vectors++;
          if (rsp_valid !== 1'b1 || rsp_line !== model[idx]) begin
            miscompares++;
            $display("FAIL rand_hold[%0d.%0d]: valid=%b line=%h, required 1/%h", i, j, rsp_valid, rsp_line, model[idx]);
          end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_release[%0d]: valid=%b, required 0", i, rsp_valid);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int lat; line_t got; line_t d; bit seen;
    d = rnd_line();
    rsp_ready = 1'b1;
    do_write(line_addr_t'(26'h2A), d);
    wait_req_ready();
    req_valid = 1'b1; req_hwrite = 1'b0; req_addr = line_addr_t'(26'h2A);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen || rsp_line !== '0) begin
      miscompares++;
      $display("FAIL reset_in_wait: response seen=%b line=%h, required 0/0", seen, rsp_line);
    end
    do_read(line_addr_t'(26'h2A), lat, got);
    vectors++;
    if (lat != RD_LAT || got !== d) begin
      miscompares++;
      $display("FAIL post_reset_read: lat=%0d data=%h, required %0d/%h (store kept)", lat, got, RD_LAT, d);
    end
    @(negedge clk);
  endtask

  task automatic test_latency1();
    line_t d0, d1; line_addr_t a;
    d0 = rnd_line(); d1 = rnd_line(); a = line_addr_t'(26'h77);
    l1_rsp_ready = 1'b1;
    l1_req_valid = 1'b1; l1_req_hwrite = 1'b1; l1_req_addr = a; l1_req_line = d0;
    @(negedge clk);
    l1_req_line = d1;
    @(negedge clk);
    vectors++;
    if (l1_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL l1_ready_after_write: ready=%b, required 1", l1_req_ready);
    end
    l1_req_hwrite = 1'b0; l1_req_line = 'x;
    @(negedge clk);
    l1_req_valid = 1'b0; l1_req_addr = 'x;
    vectors++;
    if (l1_rsp_valid !== 1'b1 || l1_rsp_line !== d1 || l1_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL l1_read: valid=%b ready=%b line=%h, required 1/0/%h", l1_rsp_valid, l1_req_ready, l1_rsp_line, d1);
    end
    @(negedge clk);
    vectors++;
    if (l1_rsp_valid !== 1'b0 || l1_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL l1_release: valid=%b ready=%b, required 0/1", l1_rsp_valid, l1_req_ready);
    end
  endtask

`ifdef LLC_MEM_RSP_STATS_EN
  task automatic test_stats();
    int lat; line_t got; int exp_wr, exp_rd;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_wr = 0; exp_rd = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_write(line_addr_t'(26'h300 + i), rnd_line());
      exp_wr++;
    end
    for (int i = 0; i < 2; i++) begin
      do_read(line_addr_t'(26'h300 + i), lat, got);
      exp_rd++;
      @(negedge clk);
    end
    vectors++;
    if (wr_count !== 32'(exp_wr) || rd_count !== 32'(exp_rd)) begin
      miscompares++;
      $display("FAIL stats: wr=%0d rd=%0d, required %0d/%0d", wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_read();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    test_latency1();
`ifdef LLC_MEM_RSP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
